// File: rtl/seq_shifter_pkg.sv
// seq_shift_pkg: shared encodings for the multi-cycle shifter.
//   MODE_*  : operation select carried on the mode port
//   state_t : controller state encoding (IDLE / SHIFT / DONE)
package seq_shift_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/result bundle for seq_shifter.
//   master : requester (drives start/mode/din/shamt, observes busy/done/dout)
//   slave  : the shifter itself
interface seq_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               start;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   din;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   dout;

    modport master (output start, mode, din, shamt, input busy, done, dout);
    modport slave  (input start, mode, din, shamt, output busy, done, dout);
endinterface

// File: rtl/seq_shifter_shift_step.sv
// shift_step: combinational single-step shifter.
//   work  : operand
//   k     : bits to shift this step, 0..STEP
//   mode  : SLL / SRL / SRA / ROL
//   sign  : fill bit for SRA (sign captured at accept, not work's MSB)
//   res   : shifted result
// One constant-distance candidate per legal k, then a mux on k, so no
// shifter wider than STEP positions is built.
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = 6
) (
    input  logic [WIDTH-1:0] work,
    input  logic [KW-1:0]    k,
    input  logic [1:0]       mode,
    input  logic             sign,
    output logic [WIDTH-1:0] res
);

    logic [STEP:0][WIDTH-1:0] cand;

    for (genvar i = 0; i <= STEP; i++) begin : g_k
        assign cand[i] =
            (mode == MODE_SLL) ? (work << i) :
            (mode == MODE_SRL) ? (work >> i) :
            (mode == MODE_SRA) ? ((work >> i) | (sign ? ~({WIDTH{1'b1}} >> i) : '0)) :
                                 ((work << i) | (work >> (WIDTH - i)));
    end

    always_comb begin
        res = cand[0];
        for (int i = 1; i <= STEP; i++) begin
            if (k == KW'(i)) res = cand[i];
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit, up to STEP bits per clock.
//   clk, reset : clock, synchronous active-high reset
//   bus        : seq_shifter_if.slave (start/mode/din/shamt in,
//                busy/done/dout out)
// Operands are captured on accept; dout is only updated on SHIFT->DONE
// and holds until the next result. A start seen in DONE is accepted
// directly, so back-to-back ops have no idle gap.
module seq_shifter
    import seq_shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic          clk,
    input  logic          reset,
    seq_shifter_if.slave  bus
);

    // k must be able to hold STEP itself, which may exceed cnt's range
    localparam int KW = SHAMT_W + 1;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   dout_q;
    logic [WIDTH-1:0]   step_res;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         mode_q;
    logic               sign_q;
    logic [KW-1:0]      k;

    // k = min(STEP, cnt); never exceeds cnt, so cnt - k cannot wrap
    always_comb begin
        k = KW'(cnt);
        if (int'(cnt) >= STEP) k = KW'(STEP);
    end

    shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
        .work (work),
        .k    (k),
        .mode (mode_q),
        .sign (sign_q),
        .res  (step_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            work   <= '0;
            cnt    <= '0;
            mode_q <= MODE_SLL;
            sign_q <= 1'b0;
            dout_q <= '0;
        end else begin
            unique case (state)
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        dout_q <= work;
                        state  <= ST_DONE;
                    end else begin
                        work <= step_res;
                        cnt  <= cnt - SHAMT_W'(k);
                    end
                end
                default: begin
                    // IDLE or DONE: both may accept a new op
                    if (bus.start) begin
                        work   <= bus.din;
                        cnt    <= bus.shamt;
                        mode_q <= bus.mode;
                        sign_q <= bus.din[WIDTH-1];
                        state  <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (state == ST_SHIFT);
    assign bus.done = (state == ST_DONE);
    assign bus.dout = dout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed vectors against two shifter instances
// (STEP=1 and STEP=4) sharing one clock and reset.
module tb_seq_shifter;
    import seq_shift_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) if1 ();
    seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) if4 ();

    seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic [1:0] m,
                         input logic [31:0] d, input logic [4:0] s);
        if (sel) begin
            if4.start = st; if4.mode = m; if4.din = d; if4.shamt = s;
        end else begin
            if1.start = st; if1.mode = m; if1.din = d; if1.shamt = s;
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? if4.busy : if1.busy;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? if4.done : if1.done;
    endfunction
    function automatic logic [31:0] get_dout(input bit sel);
        return sel ? if4.dout : if1.dout;
    endfunction

    // Issue one op; lat = edges from accept to done, bcnt = busy cycles
    task automatic run_op(input bit sel, input logic [1:0] m, input logic [31:0] d,
                          input logic [4:0] s, output logic [31:0] q,
                          output int lat, output int bcnt);
        @(negedge clk);
        drive(sel, 1'b1, m, d, s);
        @(posedge clk); #1;
        drive(sel, 1'b0, m, d, s);
        bcnt = int'(get_busy(sel));
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (get_done(sel)) break;
            bcnt += int'(get_busy(sel));
        end
        q = get_dout(sel);
    endtask

    typedef struct {
        bit          sel;   // 0: STEP=1, 1: STEP=4
        logic [1:0]  mode;
        logic [31:0] din;
        logic [4:0]  shamt;
        logic [31:0] exp_q;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] q;
        int lat, bcnt;
        bit held;

        vecs[0]  = '{0, MODE_SLL, 32'h0000_0001,  2, 32'h0000_0004, 3};
        vecs[1]  = '{1, MODE_SRA, 32'h8000_0000, 31, 32'hFFFF_FFFF, 9};
        vecs[2]  = '{1, MODE_SRL, 32'h8000_0000, 31, 32'h0000_0001, 9};
        vecs[3]  = '{0, MODE_ROL, 32'h8000_0001,  1, 32'h0000_0003, 2};
        vecs[4]  = '{0, MODE_SRA, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF, 1};
        vecs[5]  = '{1, MODE_ROL, 32'h1234_5678,  0, 32'h1234_5678, 1};
        vecs[6]  = '{0, MODE_SRL, 32'hF000_0000,  4, 32'h0F00_0000, 5};
        vecs[7]  = '{1, MODE_SLL, 32'h0000_00FF,  8, 32'h0000_FF00, 3};
        vecs[8]  = '{1, MODE_ROL, 32'h8000_0001,  5, 32'h0000_0030, 3};
        vecs[9]  = '{0, MODE_SRA, 32'h4000_0000,  3, 32'h0800_0000, 4};
        vecs[10] = '{1, MODE_SRA, 32'hF000_0000,  6, 32'hFFC0_0000, 3};

        // Reset held 3 cycles with start asserted throughout
        drive(0, 1'b1, MODE_SLL, 32'h0000_0055, 5'd3);
        drive(1, 1'b1, MODE_SLL, 32'h0000_0055, 5'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, MODE_SLL, 32'h0, 5'd0);
        drive(1, 1'b0, MODE_SLL, 32'h0, 5'd0);
        @(posedge clk); #1;
        chk("rst_busy1", {31'b0, if1.busy}, 32'd0);
        chk("rst_done1", {31'b0, if1.done}, 32'd0);
        chk("rst_dout1", if1.dout, 32'd0);
        chk("rst_busy4", {31'b0, if4.busy}, 32'd0);
        chk("rst_done4", {31'b0, if4.done}, 32'd0);
        chk("rst_dout4", if4.dout, 32'd0);

        // Table of single ops
        for (int v = 0; v < 11; v++) begin
            run_op(vecs[v].sel, vecs[v].mode, vecs[v].din, vecs[v].shamt, q, lat, bcnt);
            chk($sformatf("v%0d_dout", v), q, vecs[v].exp_q);
            chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("v%0d_busy", v), 32'(bcnt), 32'(vecs[v].exp_lat));
        end

        // Back-to-back: start re-raised during DONE goes straight to SHIFT
        run_op(0, MODE_SLL, 32'h0000_0001, 5'd2, q, lat, bcnt);
        chk("b2b_first", q, 32'h0000_0004);
        drive(0, 1'b1, MODE_SLL, 32'h0000_0010, 5'd4);
        @(posedge clk); #1;
        drive(0, 1'b0, MODE_SLL, 32'h0, 5'd0);
        chk("b2b_nogap", {31'b0, if1.busy}, 32'd1);
        held = 1'b1;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            if (if1.dout !== 32'h0000_0004) held = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (if1.done) break;
        end
        chk("b2b_held", {31'b0, held}, 32'd1);
        chk("b2b_lat", 32'(lat), 32'd5);
        chk("b2b_second", if1.dout, 32'h0000_0100);

        // Start pulsed mid-op with different operands is ignored
        @(negedge clk);
        drive(0, 1'b1, MODE_SRL, 32'h0000_FF00, 5'd4);
        @(posedge clk); #1;
        drive(0, 1'b0, MODE_SRL, 32'h0, 5'd0);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 2) begin
                @(negedge clk);
                drive(0, 1'b1, MODE_SLL, 32'h0000_0001, 5'd1);
                @(posedge clk); #1;
                drive(0, 1'b0, MODE_SLL, 32'h0, 5'd0);
            end else begin
                @(posedge clk); #1;
            end
            lat++;
            if (if1.done) break;
        end
        chk("ign_dout", if1.dout, 32'h0000_0FF0);
        chk("ign_lat", 32'(lat), 32'd5);
        @(posedge clk); #1;
        chk("ign_idle", {31'b0, if1.busy}, 32'd0);

        // Reset mid-SHIFT: op discarded, dout cleared, no done afterwards
        @(negedge clk);
        drive(0, 1'b1, MODE_SLL, 32'h0000_0001, 5'd10);
        @(posedge clk); #1;
        drive(0, 1'b0, MODE_SLL, 32'h0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", {31'b0, if1.busy}, 32'd0);
        chk("mid_rst_dout", if1.dout, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        held = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (if1.done) held = 1'b1;
        end
        chk("mid_rst_nodone", {31'b0, held}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
